// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage and the data RAM.
// The stage is the master; the RAM answers with asynchronous read data.
interface mem_stage_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;
    logic [15:0]       mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: load/store, stack pointer, push/pop sequencing and
// the two-cycle interrupt context save (PC first, then CCR).
module mem_stage #(
    parameter int ADDR_W  = 11,
    parameter int SP_INIT = 2047
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ALU_result_mem,
    input  logic [15:0] Rs_data_mem,
    input  logic [15:0] Rd_data_mem,
    input  logic [2:0]  Rd_mem,
    input  logic        memRead_mem,
    input  logic        memWrite_mem,
    input  logic        regWrite_mem,
    input  logic        push_mem,
    input  logic        pop_mem,
    input  logic        pushPc_mem,
    input  logic        popPc_mem,
    input  logic        pushCCR_mem,
    input  logic        popCCR_mem,
    input  logic        int1_mem,
    input  logic [15:0] pc_mem,
    input  logic [2:0]  ccr_in,
    mem_stage_if.master dmem,
    output logic [15:0] wb_data,
    output logic [2:0]  Rd_wb,
    output logic        regWrite_wb,
    output logic [15:0] pc_out,
    output logic        pc_load,
    output logic [2:0]  ccr_out,
    output logic        ccr_load,
    output logic        stall,
    output logic        stack_err
);

    localparam logic [ADDR_W-1:0] SP_TOP = ADDR_W'(SP_INIT);

    typedef enum logic {
        IDLE,
        INT_CCR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              err_q, err_d;

    logic        do_push;
    logic        do_pop;
    logic        pc_pop;
    logic        ccr_pop;
    logic [15:0] push_val;
    logic        in_ccr;
    logic        ovf;
    logic        unf;
    logic        fault;

    logic unused_bits;
    assign unused_bits = ^{Rs_data_mem, ALU_result_mem[15:ADDR_W]};

    assign in_ccr = (state_q == INT_CCR);

    // Pick the single stack operation for this cycle by priority.
    always_comb begin
        do_push  = 1'b0;
        do_pop   = 1'b0;
        pc_pop   = 1'b0;
        ccr_pop  = 1'b0;
        push_val = Rd_data_mem;
        state_d  = IDLE;
        if (in_ccr) begin
            do_push  = 1'b1;
            push_val = {13'b0, ccr_in};
        end else if (int1_mem) begin
            do_push  = 1'b1;
            push_val = pc_mem;
            state_d  = INT_CCR;
        end else if (pushPc_mem) begin
            do_push  = 1'b1;
            push_val = pc_mem;
        end else if (popPc_mem) begin
            do_pop = 1'b1;
            pc_pop = 1'b1;
        end else if (pushCCR_mem) begin
            do_push  = 1'b1;
            push_val = {13'b0, ccr_in};
        end else if (popCCR_mem) begin
            do_pop  = 1'b1;
            ccr_pop = 1'b1;
        end else if (push_mem) begin
            do_push = 1'b1;
        end else if (pop_mem) begin
            do_pop = 1'b1;
        end
    end

    assign ovf   = do_push && (sp_q == '0);
    assign unf   = do_pop && (sp_q == SP_TOP);
    assign fault = ovf || unf;

    // Drive the memory bus, next SP and write-back outputs.
    always_comb begin
        dmem.mem_addr  = ALU_result_mem[ADDR_W-1:0];
        dmem.mem_wdata = Rd_data_mem;
        dmem.mem_we    = 1'b0;
        sp_d           = sp_q;
        err_d          = err_q | fault;
        if (do_push) begin
            dmem.mem_addr  = sp_q;
            dmem.mem_wdata = push_val;
            dmem.mem_we    = !ovf;
            if (!ovf) begin
                sp_d = sp_q - 1'b1;
            end
        end else if (do_pop) begin
            dmem.mem_addr = sp_q + 1'b1;
            if (!unf) begin
                sp_d = sp_q + 1'b1;
            end
        end else begin
            dmem.mem_we = memWrite_mem;
        end

        wb_data     = (memRead_mem || pop_mem) ? dmem.mem_rdata
                                               : ALU_result_mem;
        Rd_wb       = Rd_mem;
        regWrite_wb = regWrite_mem && !fault && !in_ccr;
        pc_load     = pc_pop && !unf;
        ccr_load    = ccr_pop && !unf;
        pc_out      = pc_load ? dmem.mem_rdata : 16'h0000;
        ccr_out     = ccr_load ? dmem.mem_rdata[2:0] : 3'b000;
        stall       = in_ccr;

        if (rst) begin
            dmem.mem_addr  = '0;
            dmem.mem_wdata = 16'h0000;
            dmem.mem_we    = 1'b0;
            wb_data        = 16'h0000;
            Rd_wb          = 3'b000;
            regWrite_wb    = 1'b0;
            pc_load        = 1'b0;
            ccr_load       = 1'b0;
            pc_out         = 16'h0000;
            ccr_out        = 3'b000;
            stall          = 1'b0;
        end
    end

    assign stack_err = err_q;

    // Stack pointer, interrupt FSM and sticky stack error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sp_q    <= SP_TOP;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus hand sequences,
// with expected outputs queued at drive time and popped at sample time.
module tb_mem_stage;

    typedef struct packed {
        logic        ca;
        logic [10:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic        cw;
        logic [15:0] wb;
        logic        rw;
        logic        pl;
        logic [15:0] pc;
        logic        cl;
        logic [2:0]  ccr;
        logic        st;
        logic        err;
    } exp_t;

    typedef struct {
        logic [9:0]  c;
        logic [15:0] alu;
        logic [15:0] rdd;
        logic [15:0] pc;
        logic [2:0]  ccr;
        logic [2:0]  rd;
        exp_t        e;
    } vec_t;

    localparam logic [9:0] I1  = 10'h200;
    localparam logic [9:0] PPC = 10'h100;
    localparam logic [9:0] OPC = 10'h080;
    localparam logic [9:0] PCC = 10'h040;
    localparam logic [9:0] OCC = 10'h020;
    localparam logic [9:0] PU  = 10'h010;
    localparam logic [9:0] PO  = 10'h008;
    localparam logic [9:0] MR  = 10'h004;
    localparam logic [9:0] MW  = 10'h002;
    localparam logic [9:0] RW  = 10'h001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] alu, rs, rdd, pc_in;
    logic [2:0]  rd, ccr_in;
    logic        mr, mw, rw, pu, po, ppc, opc, pcc, occ, i1;
    logic [15:0] wb_data, pc_out;
    logic [2:0]  rd_wb, ccr_out;
    logic        rw_wb, pc_load, ccr_load, stall, stack_err;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];
    logic [2:0] rdq[$];
    vec_t tbl[15];

    logic [15:0] mem [0:2047];

    always #5 clk = ~clk;

    mem_stage_if #(.ADDR_W(11)) dmem ();

    assign dmem.mem_rdata = mem[dmem.mem_addr];

    always @(posedge clk) begin
        if (dmem.mem_we) mem[dmem.mem_addr] <= dmem.mem_wdata;
    end

    mem_stage #(.ADDR_W(11), .SP_INIT(2047)) dut (
        .clk(clk), .rst(rst),
        .ALU_result_mem(alu), .Rs_data_mem(rs), .Rd_data_mem(rdd),
        .Rd_mem(rd), .memRead_mem(mr), .memWrite_mem(mw),
        .regWrite_mem(rw), .push_mem(pu), .pop_mem(po),
        .pushPc_mem(ppc), .popPc_mem(opc), .pushCCR_mem(pcc),
        .popCCR_mem(occ), .int1_mem(i1), .pc_mem(pc_in),
        .ccr_in(ccr_in), .dmem(dmem),
        .wb_data(wb_data), .Rd_wb(rd_wb), .regWrite_wb(rw_wb),
        .pc_out(pc_out), .pc_load(pc_load), .ccr_out(ccr_out),
        .ccr_load(ccr_load), .stall(stall), .stack_err(stack_err)
    );

    function automatic exp_t ex(
        logic ca, logic [10:0] addr, logic we, logic [15:0] wd,
        logic cw, logic [15:0] wb, logic rwb, logic pl,
        logic [15:0] pc, logic cl, logic [2:0] cc, logic st,
        logic err);
        exp_t e;
        e.ca = ca; e.addr = addr; e.we = we; e.wdata = wd;
        e.cw = cw; e.wb = wb; e.rw = rwb; e.pl = pl; e.pc = pc;
        e.cl = cl; e.ccr = cc; e.st = st; e.err = err;
        return e;
    endfunction

    function automatic vec_t v(
        logic [9:0] c, logic [15:0] a, logic [15:0] d,
        logic [15:0] p, logic [2:0] cc, logic [2:0] r, exp_t e);
        vec_t t;
        t.c = c; t.alu = a; t.rdd = d; t.pc = p;
        t.ccr = cc; t.rd = r; t.e = e;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clear_in();
        {i1, ppc, opc, pcc, occ, pu, po, mr, mw, rw} = 10'h000;
        alu = 16'h0; rs = 16'h0; rdd = 16'h0; pc_in = 16'h0;
        rd = 3'd0; ccr_in = 3'd0;
    endtask

    task automatic apply(input string nm, input vec_t t);
        exp_t e;
        logic [2:0] er;
        @(negedge clk);
        {i1, ppc, opc, pcc, occ, pu, po, mr, mw, rw} = t.c;
        alu = t.alu; rdd = t.rdd; pc_in = t.pc;
        ccr_in = t.ccr; rd = t.rd; rs = 16'hDEAD;
        sb.push_back(t.e);
        rdq.push_back(t.rd);
        #2;
        e  = sb.pop_front();
        er = rdq.pop_front();
        if (e.ca) chk({nm, ".addr"}, 16'(dmem.mem_addr), 16'(e.addr));
        chk({nm, ".we"}, 16'(dmem.mem_we), 16'(e.we));
        if (e.we) chk({nm, ".wdata"}, dmem.mem_wdata, e.wdata);
        if (e.cw) chk({nm, ".wb"}, wb_data, e.wb);
        chk({nm, ".rw_wb"}, 16'(rw_wb), 16'(e.rw));
        chk({nm, ".rd_wb"}, 16'(rd_wb), 16'(er));
        chk({nm, ".pc_load"}, 16'(pc_load), 16'(e.pl));
        if (e.pl) chk({nm, ".pc_out"}, pc_out, e.pc);
        chk({nm, ".ccr_load"}, 16'(ccr_load), 16'(e.cl));
        if (e.cl) chk({nm, ".ccr_out"}, 16'(ccr_out), 16'(e.ccr));
        chk({nm, ".stall"}, 16'(stall), 16'(e.st));
        chk({nm, ".err"}, 16'(stack_err), 16'(e.err));
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        {i1, ppc, opc, pcc, occ, pu, po, mr, mw, rw} = PU | RW | MW;
        alu = 16'hFFFF; rdd = 16'h5555; rd = 3'd7;
        #2;
        chk({nm, ".wb"}, wb_data, 16'h0000);
        chk({nm, ".rd_wb"}, 16'(rd_wb), 16'h0000);
        chk({nm, ".rw_wb"}, 16'(rw_wb), 16'h0000);
        chk({nm, ".we"}, 16'(dmem.mem_we), 16'h0000);
        chk({nm, ".addr"}, 16'(dmem.mem_addr), 16'h0000);
        chk({nm, ".stall"}, 16'(stall), 16'h0000);
        chk({nm, ".err"}, 16'(stack_err), 16'h0000);
        chk({nm, ".loads"}, 16'({pc_load, ccr_load}), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        clear_in();
    endtask

    initial begin
        exp_t z;
        clear_in();
        z = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = v(PU, 16'h0000, 16'hABCD, 0, 0, 0,
            ex(1, 2047, 1, 16'hABCD, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
        tbl[1]  = v(PO | RW, 16'h0000, 0, 0, 0, 3,
            ex(1, 2047, 0, 0, 1, 16'hABCD, 1, 0, 0, 0, 0, 0, 0));
        tbl[2]  = v(MW, 16'h0010, 16'h1234, 0, 0, 0,
            ex(1, 16, 1, 16'h1234, 1, 16'h0010, 0, 0, 0, 0, 0, 0, 0));
        tbl[3]  = v(MR | RW, 16'hF810, 0, 0, 0, 5,
            ex(1, 16, 0, 0, 1, 16'h1234, 1, 0, 0, 0, 0, 0, 0));
        tbl[4]  = v(PU | MW, 16'h0020, 16'h1111, 0, 0, 0,
            ex(1, 2047, 1, 16'h1111, 1, 16'h0020, 0, 0, 0, 0, 0, 0, 0));
        tbl[5]  = v(PPC | PO, 16'h0000, 0, 16'h0300, 0, 0,
            ex(1, 2046, 1, 16'h0300, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl[6]  = v(OPC, 16'h0055, 0, 0, 0, 0,
            ex(1, 2046, 0, 0, 1, 16'h0055, 0, 1, 16'h0300, 0, 0, 0, 0));
        tbl[7]  = v(PCC | PU, 16'h0000, 16'h9999, 0, 3'b011, 0,
            ex(1, 2046, 1, 16'h0003, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
        tbl[8]  = v(OCC, 16'h0000, 0, 0, 0, 0,
            ex(1, 2046, 0, 0, 1, 16'h0000, 0, 0, 0, 1, 3'b011, 0, 0));
        tbl[9]  = v(PO | RW, 16'h0000, 0, 0, 0, 2,
            ex(1, 2047, 0, 0, 1, 16'h1111, 1, 0, 0, 0, 0, 0, 0));
        tbl[10] = v(PO | RW, 16'h0000, 0, 0, 0, 1, z);
        tbl[11] = v(MW, 16'h0020, 16'h5A5A, 0, 0, 0,
            ex(1, 32, 1, 16'h5A5A, 1, 16'h0020, 0, 0, 0, 0, 0, 0, 1));
        tbl[12] = v(OPC | RW, 16'h0077, 0, 0, 0, 4,
            ex(0, 0, 0, 0, 1, 16'h0077, 0, 0, 0, 0, 0, 0, 1));
        tbl[13] = v(PU, 16'h0000, 16'h7777, 0, 0, 0,
            ex(1, 2047, 1, 16'h7777, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 1));
        tbl[14] = v(PO | RW, 16'h0000, 0, 0, 0, 6,
            ex(1, 2047, 0, 0, 1, 16'h7777, 1, 0, 0, 0, 0, 0, 1));

        do_reset("rst0");
        for (int i = 0; i < 15; i++) begin
            apply($sformatf("tbl[%0d]", i), tbl[i]);
        end

        do_reset("rst1");
        apply("int.pc", v(I1, 0, 0, 16'h0200, 3'b101, 0,
            ex(1, 2047, 1, 16'h0200, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
        apply("int.ccr", v(I1 | PU, 0, 16'hFFFF, 16'h0200, 3'b101, 0,
            ex(1, 2046, 1, 16'h0005, 1, 0, 0, 0, 0, 0, 0, 1, 0)));
        apply("int.popccr", v(OCC, 0, 0, 0, 0, 0,
            ex(1, 2046, 0, 0, 1, 0, 0, 0, 0, 1, 3'b101, 0, 0)));
        apply("int.poppc", v(OPC, 0, 0, 0, 0, 0,
            ex(1, 2047, 0, 0, 1, 0, 0, 1, 16'h0200, 0, 0, 0, 0)));

        apply("mid.pc", v(I1, 0, 0, 16'h0300, 3'b001, 0,
            ex(1, 2047, 1, 16'h0300, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
        do_reset("mid.rst");
        apply("mid.push", v(PU, 0, 16'h4444, 0, 0, 0,
            ex(1, 2047, 1, 16'h4444, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
        apply("re.pc", v(I1, 0, 0, 16'h0400, 3'b010, 0,
            ex(1, 2046, 1, 16'h0400, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
        apply("re.ccr", v(I1, 0, 0, 16'h0400, 3'b010, 0,
            ex(1, 2045, 1, 16'h0002, 1, 0, 0, 0, 0, 0, 0, 1, 0)));
        apply("re.after", v(MW, 16'h0040, 16'h0BAD, 0, 0, 0,
            ex(1, 64, 1, 16'h0BAD, 1, 16'h0040, 0, 0, 0, 0, 0, 0, 0)));

        do_reset("rst2");
        for (int i = 0; i < 2047; i++) begin
            apply("fill", v(PU, 0, 16'(i), 0, 0, 0,
                ex(1, 11'(2047 - i), 1, 16'(i), 1, 0, 0, 0, 0, 0, 0, 0,
                   0)));
        end
        apply("ovf.push", v(PU | RW, 0, 16'hEEEE, 0, 0, 1,
            ex(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
        apply("ovf.sticky", v(RW, 16'h0099, 0, 0, 0, 2,
            ex(0, 0, 0, 0, 1, 16'h0099, 1, 0, 0, 0, 0, 0, 1)));
        apply("ovf.pop", v(PO | RW, 0, 0, 0, 0, 3,
            ex(1, 1, 0, 0, 1, 16'd2046, 1, 0, 0, 0, 0, 0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
